// File: rtl/prog_load_ctrl.sv
// rtl/prog_load_ctrl.sv - UART boot loader writing an image into instruction memory (option: PROG_CHECKSUM_EN)
module prog_load_ctrl #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter logic [31:0] MAGIC          = 32'h4E4B_4554,
  parameter int unsigned MAX_WORDS      = 16384,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        program_rx_i,
  output logic        prog_mode_o,
  output logic        core_rst_no,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i
);

  localparam int unsigned CPB     = CLK_FREQ / BAUD;
  localparam logic [31:0] HALF_M1 = 32'(CPB / 2 - 1);
  localparam logic [31:0] CPB_M1  = 32'(CPB - 1);
  localparam logic [31:0] TO_M1   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MAXW    = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
`ifdef PROG_CHECKSUM_EN
  typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_DATA, ST_WRITE, ST_CSUM, ST_DONE, ST_ABORT} state_e;
`else
  typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_DATA, ST_WRITE, ST_DONE, ST_ABORT} state_e;
`endif

  // receiver state
  rx_state_e   rx_state_q, rx_state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bits_q, rx_bits_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_vld_q, rx_vld_d;

  // session state
  state_e      state_q, state_d;
  logic [31:0] window_q, window_d, len_q, len_d, idx_q, idx_d, to_cnt_q, to_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_q, pend_d;
  logic        prog_mode_q, prog_mode_d, core_rst_n_q, core_rst_n_d, mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        err_q, err_d, blink_q, blink_d;
  logic [21:0] blink_cnt_q, blink_cnt_d;
`endif

  logic        in_vld, timeout_hit;
  logic [7:0]  in_byte;
  logic [31:0] win_nxt, len_nxt, wdata_nxt;

  // 8N1 receiver: synchronise, detect start edge, sample at bit centres
  always_comb begin
    sync1_d    = program_rx_i;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 32'd1;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_vld_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 32'd0;
        if (rx_prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d   = 32'd0;
        rx_bits_d  = 3'd0;
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CPB_M1) begin
        rx_cnt_d   = 32'd0;
        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
        rx_bits_d  = rx_bits_q + 3'd1;
        if (rx_bits_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CPB_M1) begin
        rx_cnt_d   = 32'd0;
        rx_vld_d   = sync2_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // session FSM: hunt for MAGIC, collect length and words, issue writes
  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    len_d        = len_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    pend_vld_d   = pend_vld_q;
    pend_d       = pend_q;
    prog_mode_d  = prog_mode_q;
    core_rst_n_d = core_rst_n_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef PROG_CHECKSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
    blink_cnt_d  = err_q ? blink_cnt_q + 22'd1 : 22'd0;
    blink_d      = err_q ? (blink_q ^ (&blink_cnt_q)) : 1'b0;
`endif
    // bytes landing during WRITE wait in the pending slot
    in_vld  = (state_q != ST_WRITE) && (rx_vld_q || pend_vld_q);
    in_byte = pend_vld_q ? pend_q : rx_shift_q;
    if (state_q == ST_WRITE) begin
      if (rx_vld_q) begin
        pend_vld_d = 1'b1;
        pend_d     = rx_shift_q;
      end
    end else if (pend_vld_q) begin
      pend_vld_d = rx_vld_q;
      pend_d     = rx_shift_q;
    end
    win_nxt   = {in_byte, window_q[31:8]};
    len_nxt   = {in_byte, len_q[31:8]};
    wdata_nxt = {in_byte, mem_wdata_q[31:8]};
    to_cnt_d  = 32'd0;
    if ((state_q == ST_LEN || state_q == ST_DATA) && !rx_vld_q) to_cnt_d = to_cnt_q + 32'd1;
    timeout_hit = (state_q == ST_LEN || state_q == ST_DATA) && (to_cnt_q == TO_M1);
    case (state_q)
      ST_HUNT: if (in_vld) begin
        window_d = win_nxt;
        if (win_nxt == MAGIC) begin
          state_d      = ST_LEN;
          window_d     = 32'd0;
          prog_mode_d  = 1'b1;
          core_rst_n_d = 1'b0;
          byte_cnt_d   = 2'd0;
          idx_d        = 32'd0;
`ifdef PROG_CHECKSUM_EN
          csum_d       = 8'd0;
          err_d        = 1'b0;
`endif
        end
      end
      ST_LEN: if (in_vld) begin
        len_d      = len_nxt;
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROG_CHECKSUM_EN
        csum_d     = csum_q ^ in_byte;
`endif
        if (byte_cnt_q == 2'd3) begin
          if (len_nxt == 32'd0)      state_d = ST_DONE;
          else if (len_nxt > MAXW)   state_d = ST_ABORT;
          else                       state_d = ST_DATA;
        end
      end else if (timeout_hit) state_d = ST_ABORT;
      ST_DATA: if (in_vld) begin
        mem_wdata_d = wdata_nxt;
        byte_cnt_d  = byte_cnt_q + 2'd1;
`ifdef PROG_CHECKSUM_EN
        csum_d      = csum_q ^ in_byte;
`endif
        if (byte_cnt_q == 2'd3) begin
          state_d    = ST_WRITE;
          mem_req_d  = 1'b1;
          mem_addr_d = BASE_ADDR + (idx_q << 2);
        end
      end else if (timeout_hit) state_d = ST_ABORT;
      ST_WRITE: if (mem_ack_i) begin
        mem_req_d = 1'b0;
        idx_d     = idx_q + 32'd1;
`ifdef PROG_CHECKSUM_EN
        state_d   = (idx_q + 32'd1 == len_q) ? ST_CSUM : ST_DATA;
`else
        state_d   = (idx_q + 32'd1 == len_q) ? ST_DONE : ST_DATA;
`endif
      end
`ifdef PROG_CHECKSUM_EN
      ST_CSUM: if (in_vld) begin
        if (in_byte == csum_q) state_d = ST_DONE;
        else begin
          state_d = ST_ABORT;
          err_d   = 1'b1;
        end
      end
`endif
      ST_DONE, ST_ABORT: begin
        state_d      = ST_HUNT;
        prog_mode_d  = 1'b0;
        core_rst_n_d = 1'b1;
        window_d     = 32'd0;
        byte_cnt_d   = 2'd0;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= 32'd0;
      rx_bits_q    <= 3'd0;
      rx_shift_q   <= 8'd0;
      rx_vld_q     <= 1'b0;
      state_q      <= ST_HUNT;
      window_q     <= 32'd0;
      len_q        <= 32'd0;
      idx_q        <= 32'd0;
      to_cnt_q     <= 32'd0;
      byte_cnt_q   <= 2'd0;
      pend_vld_q   <= 1'b0;
      pend_q       <= 8'd0;
      prog_mode_q  <= 1'b0;
      core_rst_n_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
`ifdef PROG_CHECKSUM_EN
      csum_q       <= 8'd0;
      err_q        <= 1'b0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= 22'd0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bits_q    <= rx_bits_d;
      rx_shift_q   <= rx_shift_d;
      rx_vld_q     <= rx_vld_d;
      state_q      <= state_d;
      window_q     <= window_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      to_cnt_q     <= to_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      pend_vld_q   <= pend_vld_d;
      pend_q       <= pend_d;
      prog_mode_q  <= prog_mode_d;
      core_rst_n_q <= core_rst_n_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef PROG_CHECKSUM_EN
      csum_q       <= csum_d;
      err_q        <= err_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
`endif
    end
  end

`ifdef PROG_CHECKSUM_EN
  assign prog_mode_o = err_q ? blink_q : prog_mode_q;
`else
  assign prog_mode_o = prog_mode_q;
`endif
  assign core_rst_no = core_rst_n_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb/tb_prog_load_ctrl.sv - scoreboard bench for prog_load_ctrl
module tb_prog_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        mem_ack = 1'b0;
  logic        prog_mode_o, core_rst_no, mem_req_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  int total = 0;
  int bad   = 0;
  int writes = 0;
  int req_cycles = 0;
  int ack_wait = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  localparam logic [31:0] MAGIC = 32'h4E4B_4554;

  always #5 clk = ~clk;

  prog_load_ctrl #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .BASE_ADDR(32'h0),
    .MAGIC(MAGIC), .MAX_WORDS(16384), .TIMEOUT_CYCLES(500)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .program_rx_i(rx),
    .prog_mode_o(prog_mode_o), .core_rst_no(core_rst_no),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack)
  );

  // memory model: acks each request on its third cycle and scores the write
  always @(negedge clk) begin
    if (mem_req_o) req_cycles++;
    if (rst_n !== 1'b1) begin
      mem_ack  = 1'b0;
      ack_wait = 0;
    end else if (mem_req_o && !mem_ack) begin
      ack_wait++;
      if (ack_wait == 3) begin
        mem_ack  = 1'b1;
        ack_wait = 0;
        writes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h", mem_addr_o, mem_wdata_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_addr_o !== e.addr) begin
            bad++;
            $display("FAIL write_addr got=%h exp=%h", mem_addr_o, e.addr);
          end
          total++;
          if (mem_wdata_o !== e.data) begin
            bad++;
            $display("FAIL write_data got=%h exp=%h", mem_wdata_o, e.data);
          end
        end
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_mode(input logic val, input int max, output int n);
    n = 0;
    while (prog_mode_o !== val && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int r0;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%b exp=1", core_rst_no); end
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL reset_prog_mode got=%b exp=0", prog_mode_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    total++; if (mem_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
    rst_n = 1'b1;
    r0 = req_cycles;
    repeat (100) @(negedge clk);
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL idle_core_rst got=%b exp=1", core_rst_no); end
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL idle_prog_mode got=%b exp=0", prog_mode_o); end
    total++; if (req_cycles !== r0) begin bad++; $display("FAIL idle_no_req got=%0d exp=%0d", req_cycles - r0, 0); end
  endtask

  task automatic test_load();
    int w0, n;
    w0 = writes;
    exp_q.push_back('{addr: 32'h0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 32'h4, data: 32'h0000_006F});
    send_word(MAGIC);
    total++; if (prog_mode_o !== 1'b1) begin bad++; $display("FAIL load_mode_on got=%b exp=1", prog_mode_o); end
    total++; if (core_rst_no !== 1'b0) begin bad++; $display("FAIL load_core_held got=%b exp=0", core_rst_no); end
    send_word(32'd2);
    send_word(32'h13);
    total++; if (core_rst_no !== 1'b0) begin bad++; $display("FAIL load_core_held_mid got=%b exp=0", core_rst_no); end
    send_word(32'h6F);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h7E, 1'b1);
`endif
    wait_mode(1'b0, 200, n);
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL load_done_mode got=%b exp=0", prog_mode_o); end
    repeat (2) @(negedge clk);
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL load_core_released got=%b exp=1", core_rst_no); end
    total++; if (writes - w0 !== 2) begin bad++; $display("FAIL load_write_count got=%0d exp=2", writes - w0); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL load_sb_empty got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_len_edge(input logic [31:0] n_words, input string tag);
    int w0;
    w0 = writes;
    send_word(MAGIC);
    total++; if (prog_mode_o !== 1'b1) begin bad++; $display("FAIL %s_open got=%b exp=1", tag, prog_mode_o); end
    send_word(n_words);
    repeat (3) @(negedge clk);
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL %s_mode got=%b exp=0", tag, prog_mode_o); end
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL %s_core_rst got=%b exp=1", tag, core_rst_no); end
    total++; if (writes !== w0) begin bad++; $display("FAIL %s_no_write got=%0d exp=%0d", tag, writes, w0); end
  endtask

  task automatic test_timeout();
    int w0, n;
    w0 = writes;
    send_word(MAGIC);
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    total++; if (prog_mode_o !== 1'b1) begin bad++; $display("FAIL timeout_still_open got=%b exp=1", prog_mode_o); end
    wait_mode(1'b0, 700, n);
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL timeout_abort got=%b exp=0", prog_mode_o); end
    total++; if (n < 450 || n > 550) begin bad++; $display("FAIL timeout_latency got=%0d exp=450..550", n); end
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL timeout_core_rst got=%b exp=1", core_rst_no); end
    total++; if (writes !== w0) begin bad++; $display("FAIL timeout_no_write got=%0d exp=%0d", writes, w0); end
  endtask

  task automatic test_bad_stop();
    send_byte(8'h54, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'h4B, 1'b0);
    send_byte(8'h4E, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL badstop_not_open got=%b exp=0", prog_mode_o); end
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL badstop_core_rst got=%b exp=1", core_rst_no); end
    send_word(MAGIC);
    total++; if (prog_mode_o !== 1'b1) begin bad++; $display("FAIL badstop_recover got=%b exp=1", prog_mode_o); end
    send_word(32'd0);
    repeat (3) @(negedge clk);
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL badstop_close got=%b exp=0", prog_mode_o); end
  endtask

`ifdef PROG_CHECKSUM_EN
  task automatic test_checksum();
    exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
    send_word(MAGIC);
    send_word(32'd1);
    send_word(32'h4433_2211);
    send_byte(8'h45, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (prog_mode_o !== 1'b0) begin bad++; $display("FAIL csum_ok_done got=%b exp=0", prog_mode_o); end
    total++; if (dut.err_q !== 1'b0) begin bad++; $display("FAIL csum_ok_err got=%b exp=0", dut.err_q); end
    exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
    send_word(MAGIC);
    send_word(32'd1);
    send_word(32'h4433_2211);
    send_byte(8'h00, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (dut.err_q !== 1'b1) begin bad++; $display("FAIL csum_bad_err got=%b exp=1", dut.err_q); end
    total++; if (core_rst_no !== 1'b1) begin bad++; $display("FAIL csum_bad_core_rst got=%b exp=1", core_rst_no); end
    send_word(MAGIC);
    total++; if (dut.err_q !== 1'b0) begin bad++; $display("FAIL csum_err_clear got=%b exp=0", dut.err_q); end
    send_word(32'd0);
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL csum_sb_empty got=%0d exp=0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_len_edge(32'd0, "zero_len");
    test_len_edge(32'h4001, "too_long");
    test_timeout();
    test_bad_stop();
`ifdef PROG_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
